// File: rtl/poly_op_seq_if.sv
// poly_op_seq_if: handshake between the Kyber controller and the operation sequencer
interface poly_op_seq_if;
    logic       start;
    logic [1:0] mode_in;
    logic       abort;
    logic       start_ready;
    logic       busy;
    logic [1:0] mode;
    logic [7:0] clk_counter;
    logic       rd_en;
    logic       wr_en;
    logic       done;
    modport master (
        output start, mode_in, abort,
        input  start_ready, busy, mode, clk_counter, rd_en, wr_en, done
    );
    modport slave (
        input  start, mode_in, abort,
        output start_ready, busy, mode, clk_counter, rd_en, wr_en, done
    );
endinterface

// File: rtl/poly_op_seq.sv
// poly_op_seq: sequences one NTT/INVNTT/MULT/ADDSUB pass over the poly RAM
module poly_op_seq #(
    parameter int NTT_RD_LEN  = 224,
    parameter int NTT_WB_LAT  = 7,
    parameter int MULT_RD_LEN = 128,
    parameter int MULT_WB_LAT = 13,
    parameter int AS_RD_LEN   = 64,
    parameter int AS_WB_LAT   = 5
) (
    input  logic          clk,
    input  logic          rst,
    poly_op_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx, rd_len, lat, end_cnt, diff;
    logic [1:0] mode, mode_nx;
    logic       act, win;

    // per-mode read length and writeback latency, taken from the latched mode
    always_comb begin
        rd_len  = mode == 2'd3 ? 8'(AS_RD_LEN) : mode == 2'd2 ? 8'(MULT_RD_LEN) : 8'(NTT_RD_LEN);
        lat     = mode == 2'd3 ? 8'(AS_WB_LAT) : mode == 2'd2 ? 8'(MULT_WB_LAT) : 8'(NTT_WB_LAT);
        end_cnt = rd_len + lat - 8'd1;
    end

    // strobes: reads cover the READ phase, writes trail them by the pipeline latency
    always_comb begin
        act  = state == READ || state == DRAIN;
        win  = act && cnt >= lat && cnt <= end_cnt;
        diff = cnt - lat;
        bus.wr_en = win && (mode == 2'd3 ? diff[0] : mode == 2'd2 ? &diff[1:0] : 1'b1);
        bus.rd_en = state == READ;
        bus.busy = act;
        bus.start_ready = state == IDLE;
        bus.done = state == DONE;
        bus.mode = mode;
        bus.clk_counter = cnt;
    end

    // next state; abort only matters while an operation is running
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mode_nx  = mode;
        unique case (state)
            IDLE: begin
                cnt_nx = 8'd0;
                if (bus.start) begin
                    state_nx = READ;
                    mode_nx  = bus.mode_in;
                end
            end
            READ: begin
                cnt_nx = cnt + 8'd1;
                if (cnt == rd_len - 8'd1) state_nx = DRAIN;
                if (bus.abort) begin
                    state_nx = IDLE;
                    cnt_nx   = 8'd0;
                end
            end
            DRAIN: begin
                cnt_nx = cnt + 8'd1;
                if (cnt == end_cnt) begin
                    state_nx = DONE;
                    cnt_nx   = 8'd0;
                end
                if (bus.abort) begin
                    state_nx = IDLE;
                    cnt_nx   = 8'd0;
                end
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    // state, counter and mode registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            mode  <= 2'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            mode  <= mode_nx;
        end
    end
endmodule

// File: tb/tb_poly_op_seq.sv
// tb_poly_op_seq: directed scoreboard bench for the operation sequencer
module tb_poly_op_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tick = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   rd_seen = 0;
    int   done_seen = 0;
    int   rd0 = 0;
    int   dn0 = 0;
    int   t0 = 0;
    int   wq[$];

    poly_op_seq_if bus();
    poly_op_seq dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int end_of(input logic [1:0] m);
        return m == 2'd2 ? 140 : m == 2'd3 ? 68 : 230;
    endfunction

    function automatic int lat_of(input logic [1:0] m);
        return m == 2'd2 ? 13 : m == 2'd3 ? 5 : 7;
    endfunction

    function automatic int rdlen_of(input logic [1:0] m);
        return m == 2'd2 ? 128 : m == 2'd3 ? 64 : 224;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_en) begin
                check("rd_cnt", bus.clk_counter, rd_seen - rd0);
                rd_seen++;
            end
            if (bus.wr_en) begin
                if (wq.size() == 0) check("wr_unexpected", bus.wr_en, 1'b0);
                else check("wr_cnt", bus.clk_counter, wq.pop_front());
            end
            if (bus.done) done_seen++;
        end
    end

    task automatic start_op(input logic [1:0] m, input int cut);
        int last;
        last = end_of(m) < cut ? end_of(m) : cut;
        for (int c = lat_of(m); c <= last; c++)
            if (m < 2'd2 || (m == 2'd2 && c % 4 == 0) || (m == 2'd3 && c % 2 == 0)) wq.push_back(c);
        rd0 = rd_seen;
        dn0 = done_seen;
        @(negedge clk);
        bus.mode_in = m;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        t0 = tick;
    endtask

    task automatic wait_cnt(input int c);
        int k = 0;
        while (bus.clk_counter !== 8'(c) && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("wait_cnt", bus.clk_counter, c);
    endtask

    task automatic wait_done(input logic [1:0] m);
        while (bus.done !== 1'b1 && tick - t0 < 400) begin
            @(negedge clk);
            #1;
        end
        check("done_lat", tick - t0 + 1, end_of(m) + 2);
        check("done_once", done_seen - dn0, 1);
        check("rd_total", rd_seen - rd0, rdlen_of(m));
        check("wr_left", wq.size(), 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, bus.start_ready, 1'b1);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_cnt"}, bus.clk_counter, 8'd0);
        check({tag, "_rd"}, bus.rd_en, 1'b0);
        check({tag, "_wr"}, bus.wr_en, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode_in = 2'd0;
        bus.abort = 1'b0;
        #1;
        check_idle("reset");
        check("reset_mode", bus.mode, 2'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        start_op(2'd0, 999);
        check("ntt_busy", bus.busy, 1'b1);
        check("ntt_rd_first", bus.rd_en, 1'b1);
        check("ntt_cnt0", bus.clk_counter, 8'd0);
        check("ntt_mode", bus.mode, 2'd0);
        wait_done(2'd0);
        @(negedge clk);
        #1;
        check_idle("ntt_after");

        start_op(2'd1, 100);
        check("inv_mode", bus.mode, 2'd1);
        wait_cnt(100);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check_idle("abort");
        check("abort_rd_total", rd_seen - rd0, 101);
        check("abort_wr_left", wq.size(), 0);
        check("abort_no_done", done_seen - dn0, 0);

        start_op(2'd2, 999);
        check("mult_busy", bus.busy, 1'b1);
        check("mult_mode", bus.mode, 2'd2);
        wait_cnt(135);
        bus.mode_in = 2'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("drain_start_cnt", bus.clk_counter, 8'd136);
        check("drain_start_mode", bus.mode, 2'd2);
        check("drain_start_busy", bus.busy, 1'b1);
        wait_done(2'd2);
        bus.mode_in = 2'd0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_idle("done_start");
        check("done_start_mode", bus.mode, 2'd2);

        bus.abort = 1'b1;
        start_op(2'd3, 999);
        bus.abort = 1'b0;
        check("b2b_busy", bus.busy, 1'b1);
        check("b2b_mode", bus.mode, 2'd3);
        bus.mode_in = 2'd0;
        repeat (10) @(negedge clk);
        #1;
        check("as_mode_held", bus.mode, 2'd3);
        wait_done(2'd3);
        @(negedge clk);
        #1;
        check_idle("as_after");

        start_op(2'd0, 50);
        wait_cnt(50);
        #1;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        check("async_rst_mode", bus.mode, 2'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        #1;
        check("rst_no_done", done_seen - dn0, 0);
        check("rst_rd_total", rd_seen - rd0, 51);
        check("rst_wr_left", wq.size(), 0);
        check_idle("rst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
